wb_shared_interconnect: RTL
===========================

# wb_shared_interconnect

Parametrised Wishbone B4 classic shared-bus interconnect connecting M masters to N slaves inside `soc`. It replaces the single-master, combinational `wb_interconnect` and adds:
- round-robin arbitration between masters;
- inclusive address-range decode;
- error termination for unmapped addresses;
- a watchdog that error-terminates stalled slave cycles.

Only one master owns the bus at a time, and it keeps ownership for the whole of its `cyc` burst.

## Interface
- `M`, default 2: number of masters, 1..8.
- `N`, default 2: number of slaves, 1..16.
- `AddrRanges`, default {32'h0, 32'hFF, 32'h100, 32'h1FF}: 2*N 32-bit words as {base, last} pairs, slave 0 first. Both bounds are inclusive.
- `TimeoutCycles`, default 255: wait cycles without ack/err before forced err. Must be ≥1.
- `clk_in`  in  1  the single clock; all state changes on its rising edge.
- `reset_in`  in  1  asynchronous, active-low reset.
- `bus_in`  slave-side modport  wb_bus ×M  master ports. Signals: addr, dat_w, sel, we, cyc, stb in; dat_r, ack, err out.
- `bus_out`  master-side modport  wb_bus ×N  slave ports. Signals: addr, dat_w, sel, we, cyc, stb out; dat_r, ack, err in.

## Operation
- State machine: IDLE, OWNED, ERR.
- **IDLE**
  - Requesters are masters with cyc=1.
  - The round-robin arbiter picks the first requester at or after `rr_ptr`, wrapping modulo M.
  - `owner` and OWNED are registered on the next edge, and `rr_ptr` becomes owner+1 mod M.
  - With no requester the state stays IDLE.
- **OWNED**
  - The owner's addr, dat_w, sel and we are forwarded to every slave.
  - cyc and stb go only to the decoded slave.
  - The decoded slave's dat_r, ack and err return to the owner.
  - Every other master sees ack=err=0 and dat_r=0.
- **Decode**
  - Combinational on the owner's addr.
  - The lowest-index slave with base ≤ addr ≤ last wins. Overlapping ranges are legal, and the lowest index has priority.
- **Unmapped**: owner stb=1 with no range hit means no slave sees stb. The block goes to ERR, which drives err=1 to the owner for exactly one cycle and then returns to OWNED.
- **Watchdog**
  - A counter increments each cycle the owner has stb=1 while the slave returns ack=0 and err=0.
  - It clears on ack, on err, and when stb falls.
  - When the count reaches TimeoutCycles: slave stb and cyc are deasserted, the block enters ERR (one-cycle err to the owner), and the counter clears.
  - The counter is $clog2(TimeoutCycles+1) bits wide and saturates; it never wraps.
- **Release**
  - Owner cyc=0 in OWNED or ERR returns the block to IDLE on the next edge.
  - Slave cyc and stb drop combinationally in the same cycle.
  - A late slave ack in that cycle is discarded.
- **Simultaneous events**
  - Slave ack and watchdog expiry in the same cycle: ack wins, and the counter clears.
  - The owner raising cyc again in the cycle after release counts as a normal request. Round-robin order still applies, so another pending master wins.

## Timing
- **Reset**
  - All bus_in ack, err and dat_r are 0.
  - All bus_out cyc, stb and we are 0.
  - addr, dat_w and sel are 0.
  - State is IDLE, `rr_ptr`=0 and the watchdog is 0.
  - Assertion clears all of the above immediately, mid-transfer included. The first grant after deassertion goes to master 0 if it requests.
- **Grant latency**: 1 cycle. Master cyc rises at edge t, and the slave sees cyc/stb from t+1.
- **Data path**: once OWNED, requests, responses and dat_r are combinational, with zero added latency.
- **Unmapped access**: err is seen 1 cycle after stb.
- **Stalled slave**: err is seen TimeoutCycles+1 cycles after stb.
- **Idle gap**: there is at least one IDLE cycle between owners.

## Structure
- `wb_pkg` holds:
  - `WB_ADDR_W`=32, `WB_DATA_W`=32 and `WB_SEL_W`=4;
  - `wb_range_t` {base, last};
  - the state enum `ic_state_e`.
- Sub-module `wb_rr_arbiter`:
  - parameter M;
  - inputs req[M], rr_ptr and enable;
  - outputs grant_valid and grant_idx.
- The decoder and watchdog stay inline.

## Test plan
- **Single master**: master 0 reads 32'h10. Slave 0 acks with dat_r=32'hCAFE one cycle after seeing stb, and master 0 receives 32'hCAFE. Slave 1 never sees stb.
- **Contention**: masters 0 and 1 both raise cyc in the same cycle. Grants follow the order 0, 1, 0, 1 over four single transfers, with one IDLE cycle between owners.
- **Unmapped**: a write to 32'h200 produces err on the next cycle for exactly one cycle. Neither slave sees stb.
- **Timeout**: with TimeoutCycles=4, a slave that never acks causes err on the 5th cycle after stb, and slave stb drops in that same cycle.
- **Owner abort**: master 1 drops cyc mid-wait. Slave cyc falls the same cycle, the block is in IDLE the next cycle, and a slave ack arriving one cycle later is not seen by any master.
- **Async reset mid-burst**: assert reset_in=0 between edges. All outputs go to 0 before the next edge. After release, master 0 is granted first.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, address-range payload and interconnect state encoding.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] base;
    logic [WB_ADDR_W-1:0] last;
  } wb_range_t;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_OWNED = 2'd1,
    IC_ERR   = 2'd2
  } ic_state_e;

  // Inclusive range match on both bounds.
  function automatic logic range_hit(input wb_range_t r, input logic [WB_ADDR_W-1:0] a);
    return (a >= r.base) && (a <= r.last);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin pick of the first requester at or after the pointer, wrapping modulo M.
module wb_rr_arbiter #(
  parameter int unsigned M     = 2,
  parameter int unsigned IDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]     i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  input  logic             i_enable,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned w_idx;
    w_idx         = 0;
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    if (i_enable) begin
      for (int unsigned k = 0; k < M; k++) begin
        w_idx = 32'(i_rr_ptr) + k;
        if (w_idx >= M) begin
          w_idx = w_idx - M;
        end
        if (!o_grant_valid && i_req[IDX_W'(w_idx)]) begin
          o_grant_valid = 1'b1;
          o_grant_idx   = IDX_W'(w_idx);
        end
      end
    end
  end

endmodule

// File: rtl/wb_shared_interconnect.sv
// Shared-bus Wishbone B4 classic interconnect: M masters, N slaves, round-robin
// ownership per cyc burst, inclusive range decode, error termination for
// unmapped addresses and a watchdog for stalled slaves.
// Master ports are i_m_*/o_m_*, slave ports are o_s_*/i_s_*, flattened per port.
module wb_shared_interconnect
  import wb_pkg::*;
#(
  parameter int unsigned                 M             = 2,
  parameter int unsigned                 N             = 2,
  parameter logic [2*N*WB_ADDR_W-1:0]    AddrRanges    = {32'h0, 32'hFF, 32'h100, 32'h1FF},
  parameter int unsigned                 TimeoutCycles = 255
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [M*WB_ADDR_W-1:0]   i_m_addr,
  input  logic [M*WB_DATA_W-1:0]   i_m_dat_w,
  input  logic [M*WB_SEL_W-1:0]    i_m_sel,
  input  logic [M-1:0]             i_m_we,
  input  logic [M-1:0]             i_m_cyc,
  input  logic [M-1:0]             i_m_stb,
  output logic [M*WB_DATA_W-1:0]   o_m_dat_r,
  output logic [M-1:0]             o_m_ack,
  output logic [M-1:0]             o_m_err,
  output logic [N*WB_ADDR_W-1:0]   o_s_addr,
  output logic [N*WB_DATA_W-1:0]   o_s_dat_w,
  output logic [N*WB_SEL_W-1:0]    o_s_sel,
  output logic [N-1:0]             o_s_we,
  output logic [N-1:0]             o_s_cyc,
  output logic [N-1:0]             o_s_stb,
  input  logic [N*WB_DATA_W-1:0]   i_s_dat_r,
  input  logic [N-1:0]             i_s_ack,
  input  logic [N-1:0]             i_s_err
);

  localparam int unsigned IDX_W  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned SIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WD_W   = $clog2(TimeoutCycles + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TimeoutCycles);

  // Range of slave idx; slave 0 occupies the most significant {base, last} pair.
  function automatic wb_range_t slave_range(input int unsigned idx);
    return wb_range_t'(AddrRanges[(2*N - 2*idx)*WB_ADDR_W - 1 -: 2*WB_ADDR_W]);
  endfunction

  ic_state_e          r_state;
  ic_state_e          w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [WD_W-1:0]    r_wd_cnt;

  logic               w_grant_valid;
  logic [IDX_W-1:0]   w_grant_idx;

  logic [WB_ADDR_W-1:0] w_own_addr;
  logic [WB_DATA_W-1:0] w_own_dat_w;
  logic [WB_SEL_W-1:0]  w_own_sel;
  logic                 w_own_we;
  logic                 w_own_cyc;
  logic                 w_own_stb;

  logic                 w_hit;
  logic [SIDX_W-1:0]    w_hit_idx;
  logic [WB_DATA_W-1:0] w_sel_dat_r;
  logic                 w_sel_ack;
  logic                 w_sel_err;

  logic w_owned;
  logic w_req_active;
  logic w_stall;
  logic w_expire;
  logic w_unmapped;

  wb_rr_arbiter #(
    .M     (M),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req         (i_m_cyc),
    .i_rr_ptr      (r_rr_ptr),
    .i_enable      (r_state == IC_IDLE),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Select the current owner's request signals.
  always_comb begin
    w_own_addr  = '0;
    w_own_dat_w = '0;
    w_own_sel   = '0;
    w_own_we    = 1'b0;
    w_own_cyc   = 1'b0;
    w_own_stb   = 1'b0;
    for (int unsigned m = 0; m < M; m++) begin
      if (IDX_W'(m) == r_owner) begin
        w_own_addr  = i_m_addr[m*WB_ADDR_W +: WB_ADDR_W];
        w_own_dat_w = i_m_dat_w[m*WB_DATA_W +: WB_DATA_W];
        w_own_sel   = i_m_sel[m*WB_SEL_W +: WB_SEL_W];
        w_own_we    = i_m_we[m];
        w_own_cyc   = i_m_cyc[m];
        w_own_stb   = i_m_stb[m];
      end
    end
  end

  // Address decode: lowest-index matching range wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int unsigned s = 0; s < N; s++) begin
      if (!w_hit && range_hit(slave_range(s), w_own_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = SIDX_W'(s);
      end
    end
  end

  // Response of the decoded slave.
  always_comb begin
    w_sel_dat_r = '0;
    w_sel_ack   = 1'b0;
    w_sel_err   = 1'b0;
    for (int unsigned s = 0; s < N; s++) begin
      if (w_hit && (SIDX_W'(s) == w_hit_idx)) begin
        w_sel_dat_r = i_s_dat_r[s*WB_DATA_W +: WB_DATA_W];
        w_sel_ack   = i_s_ack[s];
        w_sel_err   = i_s_err[s];
      end
    end
  end

  assign w_owned      = (r_state == IC_OWNED);
  assign w_req_active = w_owned && w_own_cyc && w_own_stb;
  assign w_unmapped   = w_req_active && !w_hit;
  assign w_stall      = w_req_active && w_hit && !w_sel_ack && !w_sel_err;
  assign w_expire     = w_stall && (r_wd_cnt >= WD_LIMIT);

  // State register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= IC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; release by the owner takes priority over error entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IC_IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = IC_OWNED;
        end
      end
      IC_OWNED: begin
        if (!w_own_cyc) begin
          w_state_nxt = IC_IDLE;
        end else if (w_unmapped || w_expire) begin
          w_state_nxt = IC_ERR;
        end
      end
      IC_ERR: begin
        w_state_nxt = w_own_cyc ? IC_OWNED : IC_IDLE;
      end
      default: begin
        w_state_nxt = IC_IDLE;
      end
    endcase
  end

  // Bus outputs: broadcast request fields, steer cyc/stb and route the response.
  always_comb begin
    o_s_addr  = '0;
    o_s_dat_w = '0;
    o_s_sel   = '0;
    o_s_we    = '0;
    o_s_cyc   = '0;
    o_s_stb   = '0;
    o_m_dat_r = '0;
    o_m_ack   = '0;
    o_m_err   = '0;
    if (r_state != IC_IDLE) begin
      for (int unsigned s = 0; s < N; s++) begin
        o_s_addr[s*WB_ADDR_W +: WB_ADDR_W] = w_own_addr;
        o_s_dat_w[s*WB_DATA_W +: WB_DATA_W] = w_own_dat_w;
        o_s_sel[s*WB_SEL_W +: WB_SEL_W]    = w_own_sel;
        o_s_we[s]                          = w_own_we;
      end
    end
    if (w_owned && w_own_cyc && w_hit) begin
      for (int unsigned s = 0; s < N; s++) begin
        if (SIDX_W'(s) == w_hit_idx) begin
          o_s_cyc[s] = 1'b1;
          o_s_stb[s] = w_own_stb;
        end
      end
    end
    if (w_own_cyc) begin
      for (int unsigned m = 0; m < M; m++) begin
        if (IDX_W'(m) == r_owner) begin
          if (w_owned && w_hit) begin
            o_m_dat_r[m*WB_DATA_W +: WB_DATA_W] = w_sel_dat_r;
            o_m_ack[m] = w_sel_ack;
            o_m_err[m] = w_sel_err;
          end else if (r_state == IC_ERR) begin
            o_m_err[m] = 1'b1;
          end
        end
      end
    end
  end

  // Owner capture and round-robin pointer advance on grant.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else if ((r_state == IC_IDLE) && w_grant_valid) begin
      r_owner <= w_grant_idx;
      if (w_grant_idx == IDX_W'(M - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_grant_idx + IDX_W'(1);
      end
    end
  end

  // Watchdog: counts stalled strobe cycles, saturating, cleared on any termination.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_wd_cnt <= '0;
    end else if (w_stall && !w_expire) begin
      if (r_wd_cnt < WD_LIMIT) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

endmodule
